// File: rtl/bcd_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_pkg
// Description : Shared types and constants for the serial binary-to-BCD
//               converter.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_serial_pkg;

    localparam int DIGIT_W        = 4;
    localparam int ADD3_THRESHOLD = 5;
    localparam int ADD3_OFFSET    = 3;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3
// Description : Double-dabble digit correction: adds 3 to a BCD digit >= 5.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3
    import bcd_serial_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    // 4-bit wrap is intentional: a corrected digit never exceeds 12
    assign o_digit = (i_digit >= DIGIT_W'(ADD3_THRESHOLD))
                   ? i_digit + DIGIT_W'(ADD3_OFFSET)
                   : i_digit;

endmodule
`default_nettype wire

// File: rtl/bcd_serial.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial
// Description : Sequential double-dabble binary-to-BCD converter, one bit per
//               clock, with start/done handshake and held result.
//               Define BCD_SERIAL_AUTO_EN for free-running conversion.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial
    import bcd_serial_pkg::*;
#(
    parameter int IN_WIDTH = 6,
    parameter int DIGITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int c_CNT_W = $clog2(IN_WIDTH + 1);
    localparam int c_BCD_W = DIGIT_W * DIGITS;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(IN_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t               r_state;
    logic [IN_WIDTH-1:0]  r_shreg;
    logic [c_BCD_W-1:0]   r_scratch;
    logic                 r_sticky;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_BCD_W-1:0]   r_bcd;
    logic                 r_ovf;
    logic                 r_done;

    logic [c_BCD_W-1:0]   w_adj;
    logic [c_BCD_W-1:0]   w_scratch_next;
    logic                 w_start;

`ifdef BCD_SERIAL_AUTO_EN
    logic w_unused_start;
    assign w_unused_start = start;
    assign w_start        = 1'b1;
`else
    assign w_start        = start;
`endif

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_add3 u_add3 (
                .i_digit (r_scratch[g*DIGIT_W +: DIGIT_W]),
                .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // The bit leaving the top corrected digit carries weight 10^DIGITS
    assign w_scratch_next = {w_adj[c_BCD_W-2:0], r_shreg[IN_WIDTH-1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_scratch <= '0;
            r_sticky  <= 1'b0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_shreg   <= in;
                        r_scratch <= '0;
                        r_sticky  <= 1'b0;
                        r_cnt     <= c_CNT_LOAD;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_scratch_next;
                    r_shreg   <= r_shreg << 1;
                    if (w_adj[c_BCD_W-1]) begin
                        r_sticky <= 1'b1;
                    end
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                DONE: begin
                    r_bcd   <= r_scratch;
                    r_ovf   <= r_sticky;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign bcd  = r_bcd;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire
